// File: rtl/mem_stage_wb_reg.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_wb_reg
// Brief   : MEM pipeline stage. Drives data-memory loads and stores over a
//           req/ack bus with wait states, stalls upstream while an access is
//           outstanding, aborts on timeout, and registers results into MEM/WB.
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage_wb_reg #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic [1:0]  WB_type_in,
  input  logic [2:0]  mem_type_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] reg_data2_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] pc_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall_out,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        RegWrite_wb,
  output logic        MemtoReg_wb,
  output logic [1:0]  WB_type_wb,
  output logic [4:0]  rd_addr_wb,
  output logic [31:0] alu_result_wb,
  output logic [31:0] load_data_wb,
  output logic [31:0] pc_wb
);

  // Counter must be able to hold TIMEOUT-1.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic        mem_op, is_byte, is_half, misaligned;
  logic        req, stall, merr, berr, bubble;
  logic [1:0]  lo;
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign mem_op  = MemRead_in | MemWrite_in;
  assign lo      = alu_result_in[1:0];
  // Encodings other than B/H/BU/HU are treated as a word access.
  assign is_byte = (mem_type_in == 3'b000) || (mem_type_in == 3'b100);
  assign is_half = (mem_type_in == 3'b001) || (mem_type_in == 3'b101);
  assign misaligned = (is_half && lo[0]) || (!is_byte && !is_half && (lo != 2'b00));

  // Access sequencing: issue, wait for ack, or abort after TIMEOUT request cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req       = 1'b0;
    stall     = 1'b0;
    merr      = 1'b0;
    berr      = 1'b0;
    bubble    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            merr   = 1'b1;
            bubble = 1'b1;
          end else begin
            req = 1'b1;
            if (!dm_ack) begin
              stall     = 1'b1;
              state_nxt = WAIT;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (dm_ack) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          stall     = 1'b1;
          state_nxt = ERR;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ERR: begin
        // Request already dropped; any late ack this cycle is ignored.
        berr      = 1'b1;
        bubble    = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Byte enables, lane replication and load extraction.
  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = reg_data2_in;
    if (is_byte) begin
      be_raw    = 4'b0001 << lo;
      wdata_raw = {4{reg_data2_in[7:0]}};
    end else if (is_half) begin
      be_raw    = 4'b0011 << lo;
      wdata_raw = {2{reg_data2_in[15:0]}};
    end
    byte_sel = 8'(dm_rdata >> {lo, 3'b000});
    half_sel = lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    load_ext = dm_rdata;
    if (is_byte)
      load_ext = {{24{byte_sel[7] & ~mem_type_in[2]}}, byte_sel};
    else if (is_half)
      load_ext = {{16{half_sel[15] & ~mem_type_in[2]}}, half_sel};
  end

  // Bus and control outputs; reset kills a pending request immediately.
  assign dm_req       = req & rst_n;
  assign stall_out    = stall & rst_n;
  assign misalign_err = merr & rst_n;
  assign bus_err      = berr & rst_n;
  assign dm_we        = dm_req & MemWrite_in;
  assign dm_addr      = dm_req ? {alu_result_in[31:2], 2'b00} : 32'd0;
  assign dm_be        = dm_we ? be_raw : 4'd0;
  assign dm_wdata     = dm_we ? wdata_raw : 32'd0;

  // MEM/WB register: advance when not stalled, otherwise insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_wb   <= 1'b0;
      MemtoReg_wb   <= 1'b0;
      WB_type_wb    <= 2'd0;
      rd_addr_wb    <= 5'd0;
      alu_result_wb <= 32'd0;
      load_data_wb  <= 32'd0;
      pc_wb         <= 32'd0;
    end else if (!stall) begin
      RegWrite_wb   <= RegWrite_in & ~bubble;
      MemtoReg_wb   <= MemtoReg_in & ~bubble;
      WB_type_wb    <= WB_type_in;
      rd_addr_wb    <= rd_addr_in;
      alu_result_wb <= alu_result_in;
      load_data_wb  <= (MemRead_in & ~bubble) ? load_ext : 32'd0;
      pc_wb         <= pc_in;
    end else begin
      RegWrite_wb <= 1'b0;
      MemtoReg_wb <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_wb_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage_wb_reg
// Brief   : Directed bench for mem_stage_wb_reg with a transaction-level
//           expectation model and literal spot checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_stage_wb_reg;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite_in, MemtoReg_in, MemWrite_in, MemRead_in;
  logic [1:0]  WB_type_in;
  logic [2:0]  mem_type_in;
  logic [31:0] alu_result_in, reg_data2_in, pc_in, dm_rdata;
  logic [4:0]  rd_addr_in;
  logic        dm_ack;
  logic        dm_req, dm_we, stall_out, misalign_err, bus_err;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        RegWrite_wb, MemtoReg_wb;
  logic [1:0]  WB_type_wb;
  logic [4:0]  rd_addr_wb;
  logic [31:0] alu_result_wb, load_data_wb, pc_wb;

  mem_stage_wb_reg #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .WB_type_in(WB_type_in), .mem_type_in(mem_type_in),
    .alu_result_in(alu_result_in), .reg_data2_in(reg_data2_in),
    .rd_addr_in(rd_addr_in), .pc_in(pc_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall_out(stall_out), .misalign_err(misalign_err), .bus_err(bus_err),
    .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
    .WB_type_wb(WB_type_wb), .rd_addr_wb(rd_addr_wb),
    .alu_result_wb(alu_result_wb), .load_data_wb(load_data_wb), .pc_wb(pc_wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req, we, stall, merr, berr;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        rw, mtr, ldchk;
    logic [1:0]  wbt;
    logic [4:0]  rd;
    logic [31:0] alu, ld, pc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   op_idx = 0;

  // Expected MEM/WB contents as seen in the current cycle.
  logic        m_rw = 1'b0, m_mtr = 1'b0, m_ldchk = 1'b0;
  logic [1:0]  m_wbt = '0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_alu = '0, m_ld = '0, m_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req_v, $time);
    end
  endtask

  // Per-cycle comparison against the model's queued expectations.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("dm_req", 32'(dm_req), 32'(e.req));
      chk("stall_out", 32'(stall_out), 32'(e.stall));
      chk("misalign_err", 32'(misalign_err), 32'(e.merr));
      chk("bus_err", 32'(bus_err), 32'(e.berr));
      if (e.req) begin
        chk("dm_we", 32'(dm_we), 32'(e.we));
        chk("dm_addr", dm_addr, e.addr);
        chk("dm_be", 32'(dm_be), 32'(e.be));
        if (e.we) chk("dm_wdata", dm_wdata, e.wdata);
      end
      chk("RegWrite_wb", 32'(RegWrite_wb), 32'(e.rw));
      chk("MemtoReg_wb", 32'(MemtoReg_wb), 32'(e.mtr));
      if (e.rw) begin
        chk("WB_type_wb", 32'(WB_type_wb), 32'(e.wbt));
        chk("rd_addr_wb", 32'(rd_addr_wb), 32'(e.rd));
        chk("alu_result_wb", alu_result_wb, e.alu);
        chk("pc_wb", pc_wb, e.pc);
        if (e.ldchk) chk("load_data_wb", load_data_wb, e.ld);
      end
    end
  end

  // One instruction held in EX/MEM; waits = no-ack cycles before the ack
  // (waits >= TIMEOUT means the bus never answers; a late ack is offered
  // in the abort cycle and must be ignored).
  task automatic run_op(input logic mr, input logic mw, input logic rw, input logic mtr,
                        input logic [2:0] ty, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata, input int waits);
    bit          isb, ish, mem, misal, tmo;
    logic [31:0] ld, wd, v;
    logic [3:0]  be;
    int          ncyc, sh;
    exp_t        e;
    op_idx++;
    isb = (ty == 3'b000) || (ty == 3'b100);
    ish = (ty == 3'b001) || (ty == 3'b101);
    mem = mr || mw;
    misal = (ish && (addr % 2 != 0)) || (!isb && !ish && (addr % 4 != 0));
    tmo = (waits >= TIMEOUT);
    sh = int'(addr % 4) * 8;
    if (isb) begin
      v = (rdata >> sh) & 32'd255;
      if (ty == 3'b000 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      ld = v;
      wd = (data & 32'd255) * 32'h0101_0101;
      be = 4'(1 << (addr % 4));
    end else if (ish) begin
      v = (rdata >> sh) & 32'd65535;
      if (ty == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      ld = v;
      wd = (data & 32'd65535) * 32'h0001_0001;
      be = 4'(3 << (addr % 4));
    end else begin
      ld = rdata;
      wd = data;
      be = 4'hF;
    end
    if (!mw) be = 4'h0;
    if (!mem || misal) ncyc = 1;
    else if (!tmo) ncyc = waits + 1;
    else ncyc = TIMEOUT + 1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      RegWrite_in = rw; MemtoReg_in = mtr; MemWrite_in = mw; MemRead_in = mr;
      WB_type_in = 2'(op_idx); mem_type_in = ty; alu_result_in = addr;
      reg_data2_in = data; rd_addr_in = 5'(op_idx); pc_in = 32'h1000 + 32'(op_idx) * 4;
      dm_rdata = rdata;
      dm_ack = mem && !misal && ((i == waits) || (tmo && i == TIMEOUT));
      e.req   = mem && !misal && !(tmo && i == TIMEOUT);
      e.stall = e.req && (i != waits);
      e.merr  = mem && misal;
      e.berr  = mem && !misal && tmo && (i == TIMEOUT);
      e.we    = mw;
      e.addr  = addr & 32'hFFFF_FFFC;
      e.be    = be;
      e.wdata = wd;
      e.rw = m_rw; e.mtr = m_mtr; e.ldchk = m_ldchk; e.wbt = m_wbt;
      e.rd = m_rd; e.alu = m_alu; e.ld = m_ld; e.pc = m_pc;
      exp_q.push_back(e);
      if (e.stall || e.merr || e.berr) begin
        m_rw = 1'b0; m_mtr = 1'b0;
      end else begin
        m_rw = rw; m_mtr = mtr; m_wbt = 2'(op_idx); m_rd = 5'(op_idx);
        m_alu = addr; m_pc = 32'h1000 + 32'(op_idx) * 4; m_ld = ld; m_ldchk = mr;
      end
    end
  endtask

  task automatic nop();
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_5A5A, 32'd0, 32'd0, 0);
  endtask

  task automatic clear_inputs();
    RegWrite_in = 0; MemtoReg_in = 0; MemWrite_in = 0; MemRead_in = 0;
    WB_type_in = 0; mem_type_in = 0; alu_result_in = 0; reg_data2_in = 0;
    rd_addr_in = 0; pc_in = 0; dm_rdata = 0; dm_ack = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    MemRead_in = 1'b1;
    alu_result_in = 32'h100;
    #1;
    chk("reset dm_req", 32'(dm_req), 32'd0);
    chk("reset stall_out", 32'(stall_out), 32'd0);
    chk("reset RegWrite_wb", 32'(RegWrite_wb), 32'd0);
    chk("reset load_data_wb", load_data_wb, 32'd0);
    chk("reset pc_wb", pc_wb, 32'd0);
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    nop();
    // LW, ack in the request cycle.
    run_op(1, 0, 1, 1, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 0);
    nop(); #1;
    chk("lw load_data_wb", load_data_wb, 32'hDEAD_BEEF);
    chk("lw RegWrite_wb", 32'(RegWrite_wb), 32'd1);
    // LB / LBU with wait states.
    run_op(1, 0, 1, 1, 3'b000, 32'h103, 32'd0, 32'h80FF_FFFF, 3);
    nop(); #1;
    chk("lb load_data_wb", load_data_wb, 32'hFFFF_FF80);
    run_op(1, 0, 1, 1, 3'b100, 32'h103, 32'd0, 32'h80FF_FFFF, 1);
    nop(); #1;
    chk("lbu load_data_wb", load_data_wb, 32'h0000_0080);
    run_op(1, 0, 1, 1, 3'b001, 32'h102, 32'd0, 32'h8001_1234, 0);
    run_op(1, 0, 1, 1, 3'b101, 32'h100, 32'd0, 32'h0000_F00D, 2);
    run_op(1, 0, 1, 1, 3'b000, 32'h101, 32'd0, 32'h1234_7F00, 0);
    // Stores.
    run_op(0, 1, 0, 0, 3'b001, 32'h202, 32'h1234_ABCD, 32'd0, 0); #1;
    chk("sh dm_be", 32'(dm_be), 32'h0000_000C);
    chk("sh dm_wdata", dm_wdata, 32'hABCD_ABCD);
    chk("sh dm_we", 32'(dm_we), 32'd1);
    run_op(0, 1, 0, 0, 3'b000, 32'h201, 32'h0000_0055, 32'd0, 2);
    run_op(0, 1, 0, 0, 3'b010, 32'h204, 32'hCAFE_F00D, 32'd0, 0);
    run_op(0, 1, 0, 0, 3'b011, 32'h208, 32'h0102_0304, 32'd0, 1);
    // Misaligned accesses.
    run_op(1, 0, 1, 1, 3'b010, 32'h101, 32'd0, 32'h1111_1111, 0); #1;
    chk("misalign pulse", 32'(misalign_err), 32'd1);
    chk("misalign dm_req", 32'(dm_req), 32'd0);
    chk("misalign stall", 32'(stall_out), 32'd0);
    nop(); #1;
    chk("misalign bubble", 32'(RegWrite_wb), 32'd0);
    run_op(0, 1, 0, 0, 3'b001, 32'h203, 32'h0000_7777, 32'd0, 0);
    // Timeout abort, and the ack arriving one cycle before the limit.
    run_op(1, 0, 1, 1, 3'b010, 32'h400, 32'd0, 32'h5555_AAAA, 100); #1;
    chk("timeout bus_err", 32'(bus_err), 32'd1);
    chk("timeout dm_req", 32'(dm_req), 32'd0);
    nop(); #1;
    chk("timeout bubble", 32'(RegWrite_wb), 32'd0);
    run_op(1, 0, 1, 1, 3'b010, 32'h404, 32'd0, 32'h0BAD_CAFE, TIMEOUT - 1);
    nop();
    run_op(1, 0, 1, 1, 3'b010, 32'h408, 32'd0, 32'h0000_0001, TIMEOUT);
    nop();

    // Asynchronous reset while an access is waiting.
    @(negedge clk);
    @(posedge clk); #1;
    RegWrite_in = 1; MemtoReg_in = 1; MemRead_in = 1; MemWrite_in = 0;
    mem_type_in = 3'b010; alu_result_in = 32'h300; dm_ack = 0;
    #1;
    chk("pre-reset dm_req", 32'(dm_req), 32'd1);
    chk("pre-reset stall", 32'(stall_out), 32'd1);
    @(posedge clk); #1;
    chk("wait dm_req", 32'(dm_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst dm_req", 32'(dm_req), 32'd0);
    chk("async rst stall", 32'(stall_out), 32'd0);
    chk("async rst RegWrite_wb", 32'(RegWrite_wb), 32'd0);
    chk("async rst alu_result_wb", alu_result_wb, 32'd0);
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    m_rw = 0; m_mtr = 0; m_ldchk = 0; m_wbt = 0; m_rd = 0; m_alu = 0; m_ld = 0; m_pc = 0;
    run_op(1, 0, 1, 1, 3'b010, 32'h100, 32'd0, 32'h0123_4567, 0);
    nop(); #1;
    chk("post-reset lw", load_data_wb, 32'h0123_4567);
    chk("post-reset RegWrite_wb", 32'(RegWrite_wb), 32'd1);

    repeat (3) @(posedge clk);
    #6;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
